// File: rtl/ex_stage.sv
// Execute stage: registers the ID->EX bus, computes the ALU result and issues the data-SRAM
// request. An iterative restoring divider for DIV/DIVU holds the pipeline until it finishes.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [141:0] ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         stallreq_for_ex
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} div_state_t;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (32'd0 - v) : v;
  endfunction

  logic [158:0] r_bus_p0;

  logic [31:0] w_pc, w_inst, w_rdata1, w_rdata2;
  logic [11:0] w_alu_op;
  logic [2:0]  w_sel_src1;
  logic [3:0]  w_sel_src2;
  logic        w_ram_en, w_rf_we, w_sel_rf_res;
  logic [3:0]  w_ram_wen;
  logic [4:0]  w_rf_waddr;

  // ID -> EX boundary: a bubble is inserted when ID stalls but EX moves on
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_p0 <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      r_bus_p0 <= '0;
    end else if (stall[2] == NO_STOP) begin
      r_bus_p0 <= id_to_ex_bus;
    end
  end

  assign w_pc         = r_bus_p0[158:127];
  assign w_inst       = r_bus_p0[126:95];
  assign w_alu_op     = r_bus_p0[94:83];
  assign w_sel_src1   = r_bus_p0[82:80];
  assign w_sel_src2   = r_bus_p0[79:76];
  assign w_ram_en     = r_bus_p0[75];
  assign w_ram_wen    = r_bus_p0[74:71];
  assign w_rf_we      = r_bus_p0[70];
  assign w_rf_waddr   = r_bus_p0[69:65];
  assign w_sel_rf_res = r_bus_p0[64];
  assign w_rdata1     = r_bus_p0[63:32];
  assign w_rdata2     = r_bus_p0[31:0];

  logic        [31:0] w_src1, w_src2, w_result;
  logic signed [31:0] w_src1_s, w_src2_s;

  assign w_src1 = ({32{w_sel_src1[0]}} & w_rdata1)
                | ({32{w_sel_src1[1]}} & w_pc)
                | ({32{w_sel_src1[2]}} & {27'b0, w_inst[10:6]});
  assign w_src2 = ({32{w_sel_src2[0]}} & w_rdata2)
                | ({32{w_sel_src2[1]}} & {{16{w_inst[15]}}, w_inst[15:0]})
                | ({32{w_sel_src2[2]}} & 32'd8)
                | ({32{w_sel_src2[3]}} & {16'b0, w_inst[15:0]});
  assign w_src1_s = w_src1;
  assign w_src2_s = w_src2;

  always_comb begin
    w_result = '0;
    unique case (1'b1)
      w_alu_op[11]: w_result = w_src1 + w_src2;
      w_alu_op[10]: w_result = w_src1 - w_src2;
      w_alu_op[9]:  w_result = {31'b0, (w_src1_s < w_src2_s)};
      w_alu_op[8]:  w_result = {31'b0, (w_src1 < w_src2)};
      w_alu_op[7]:  w_result = w_src1 & w_src2;
      w_alu_op[6]:  w_result = ~(w_src1 | w_src2);
      w_alu_op[5]:  w_result = w_src1 | w_src2;
      w_alu_op[4]:  w_result = w_src1 ^ w_src2;
      w_alu_op[3]:  w_result = w_src2 << w_src1[4:0];
      w_alu_op[2]:  w_result = w_src2 >> w_src1[4:0];
      w_alu_op[1]:  w_result = w_src2_s >>> w_src1[4:0];
      w_alu_op[0]:  w_result = {w_src2[15:0], 16'b0};
      default:      w_result = '0;
    endcase
  end

  logic w_is_div, w_div_signed;
  assign w_is_div     = (w_inst[31:26] == 6'b000000) &&
                        (w_inst[5:0] == 6'b011010 || w_inst[5:0] == 6'b011011);
  assign w_div_signed = ~w_inst[0];

  div_state_t  r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_quo, r_dvs, r_rem;
  logic        r_q_neg, r_r_neg;
  logic [32:0] w_shift;
  logic [33:0] w_diff;

  // Restoring step: the remainder never exceeds the divisor, so 34 bits cover the trial subtract
  assign w_shift = {r_rem, r_quo[31]};
  assign w_diff  = {1'b0, w_shift} - {2'b0, r_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_is_div) begin
          r_quo   <= neg_if(w_div_signed & w_rdata1[31], w_rdata1);
          r_dvs   <= neg_if(w_div_signed & w_rdata2[31], w_rdata2);
          r_q_neg <= w_div_signed & (w_rdata1[31] ^ w_rdata2[31]);
          r_r_neg <= w_div_signed & w_rdata1[31];
          r_rem   <= '0;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_rem <= w_diff[33] ? w_shift[31:0] : w_diff[31:0];
          r_quo <= {r_quo[30:0], ~w_diff[33]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= S_DONE;
        end
        S_DONE: if (stall[3] == NO_STOP) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  logic        w_div_done;
  logic [31:0] w_hi, w_lo;
  assign w_div_done      = w_is_div && (r_state == S_DONE);
  assign w_lo            = w_div_done ? neg_if(r_q_neg, r_quo) : 32'd0;
  assign w_hi            = w_div_done ? neg_if(r_r_neg, r_rem) : 32'd0;
  assign stallreq_for_ex = w_is_div && (r_state != S_DONE);

  assign data_sram_en    = w_ram_en;
  assign data_sram_wen   = w_ram_wen;
  assign data_sram_addr  = w_result;
  assign data_sram_wdata = w_rdata2;

  assign ex_to_mem_bus = {w_pc, w_ram_en, w_ram_wen, w_sel_rf_res, w_rf_we, w_rf_waddr,
                          w_result, w_div_done, w_div_done, w_hi, w_lo};
  assign ex_to_rf_bus  = {w_rf_we, w_rf_waddr, w_result};

  logic w_unused_bits;
  assign w_unused_bits = ^{w_inst[25:16], stall[5:4], stall[1:0], w_diff[32]};

endmodule
